parking_gate_ctrl: RTL and testbench

Parametrised entry-gate controller for the car park. It replaces the fixed 2-bit, two-digit password gate with configurable password width and value, a wait window, a retry limit with lockout, and an occupancy counter with full detection. Exit requests arriving during an entry transaction are queued. The block drives the gate LEDs and two 7-segment status digits, and sits between the entry/exit vehicle sensors and the panel display.

---
 rtl/parking_gate_ctrl_if.sv | 31 +++
 rtl/parking_gate_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/parking_gate_ctrl_if.sv
// Signal bundle between the vehicle sensors / password keypad and the
// entry-gate controller, plus the LED, 7-segment and status outputs.
interface parking_gate_ctrl_if #(
    parameter int PW_W     = 2,
    parameter int CAPACITY = 8
);
    localparam int OCC_W = $clog2(CAPACITY + 1);

    logic             entry;
    logic             exit;
    logic [PW_W-1:0]  password1;
    logic [PW_W-1:0]  password2;
    logic             pw_valid;
    logic             GREEN;
    logic             RED;
    logic [6:0]       HEX_1;
    logic [6:0]       HEX_2;
    logic [OCC_W-1:0] occupancy;
    logic             full;
    logic             locked;

    modport master (
        output entry, exit, password1, password2, pw_valid,
        input  GREEN, RED, HEX_1, HEX_2, occupancy, full, locked
    );

    modport slave (
        input  entry, exit, password1, password2, pw_valid,
        output GREEN, RED, HEX_1, HEX_2, occupancy, full, locked
    );
endinterface

// File: rtl/parking_gate_ctrl.sv
// Car-park entry gate: password check with wait window and lockout,
// occupancy tracking with queued exits, LED and 7-segment status decode.
module parking_gate_ctrl #(
    parameter int              PW_W        = 2,
    parameter logic [PW_W-1:0] PASS1       = 2'b01,
    parameter logic [PW_W-1:0] PASS2       = 2'b10,
    parameter int              CAPACITY    = 8,
    parameter int              WAIT_CYCLES = 3,
    parameter int              MAX_TRIES   = 3,
    parameter int              LOCK_CYCLES = 16,
    parameter int              BLINK_DIV   = 4
) (
    input  logic               clk,
    input  logic               rst,
    parking_gate_ctrl_if.slave gate_bus
);

    localparam int OCC_W = $clog2(CAPACITY + 1);
    localparam int WC_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int TR_W  = $clog2(MAX_TRIES + 1);
    localparam int LK_W  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int BL_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    // Active-low segment patterns {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_N     = 7'b0101011;
    localparam logic [6:0] SEG_G     = 7'b0000010;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_S     = 7'b0010010;
    localparam logic [6:0] SEG_P     = 7'b0001100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_PASS,
        S_WRONG_PASS,
        S_RIGHT_PASS,
        S_LOCK
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [WC_W-1:0]   r_wait_cnt;
    logic [TR_W-1:0]   r_tries;
    logic [OCC_W-1:0]  r_occupancy;
    logic [LK_W-1:0]   r_lock_cnt;
    logic [BL_W-1:0]   r_blink_cnt;
    logic              r_blink;
    logic              r_exit_pend;
    logic              r_exit_prev;

    logic              w_full;
    logic              w_wait_done;
    logic              w_lock_done;
    logic              w_blink_wrap;
    logic              w_pw_match;
    logic              w_attempt;
    logic              w_occ_inc;
    logic              w_state_change;
    logic              w_exit_rise;
    logic              w_service;
    logic              w_blinking;
    logic [TR_W-1:0]   w_tries_inc;
    logic [TR_W-1:0]   w_tries_next;

    assign w_full         = (r_occupancy == OCC_W'(CAPACITY));
    assign w_wait_done    = (r_wait_cnt == WC_W'(WAIT_CYCLES));
    assign w_lock_done    = (r_lock_cnt == LK_W'(LOCK_CYCLES - 1));
    assign w_blink_wrap   = (r_blink_cnt == BL_W'(BLINK_DIV - 1));
    assign w_pw_match     = (gate_bus.password1 == PASS1) && (gate_bus.password2 == PASS2);
    assign w_tries_inc    = r_tries + TR_W'(1);
    assign w_state_change = (w_state_next != r_state);
    assign w_exit_rise    = gate_bus.exit && !r_exit_prev;
    assign w_service      = (r_state == S_IDLE) && r_exit_pend;
    assign w_blinking     = (r_state == S_WRONG_PASS) || (r_state == S_RIGHT_PASS);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next       = r_state;
        w_tries_next       = r_tries;
        w_attempt          = 1'b0;
        w_occ_inc          = 1'b0;
        gate_bus.GREEN     = 1'b0;
        gate_bus.RED       = 1'b0;
        gate_bus.HEX_1     = SEG_BLANK;
        gate_bus.HEX_2     = SEG_BLANK;

        case (r_state)
            S_IDLE: begin
                if (gate_bus.entry && !w_full) w_state_next = S_WAIT_PASS;
                if (w_full) begin
                    gate_bus.RED   = 1'b1;
                    gate_bus.HEX_1 = SEG_F;
                    gate_bus.HEX_2 = SEG_L;
                end
            end
            S_WAIT_PASS: begin
                if (!gate_bus.entry)                     w_state_next = S_IDLE;
                else if (w_wait_done && gate_bus.pw_valid) w_attempt  = 1'b1;
                gate_bus.RED   = 1'b1;
                gate_bus.HEX_1 = SEG_E;
                gate_bus.HEX_2 = SEG_N;
            end
            S_WRONG_PASS: begin
                if (!gate_bus.entry)        w_state_next = S_IDLE;
                else if (gate_bus.pw_valid) w_attempt    = 1'b1;
                gate_bus.RED   = r_blink;
                gate_bus.HEX_1 = SEG_E;
                gate_bus.HEX_2 = SEG_E;
            end
            S_RIGHT_PASS: begin
                if (!gate_bus.entry) w_state_next = S_IDLE;
                gate_bus.GREEN = r_blink;
                gate_bus.HEX_1 = SEG_G;
                gate_bus.HEX_2 = SEG_O;
            end
            S_LOCK: begin
                if (w_lock_done) w_state_next = S_IDLE;
                gate_bus.RED   = 1'b1;
                gate_bus.HEX_1 = SEG_S;
                gate_bus.HEX_2 = SEG_P;
            end
            default: w_state_next = S_IDLE;
        endcase

        if (w_attempt) begin
            if (w_pw_match) begin
                w_state_next = S_RIGHT_PASS;
                w_tries_next = '0;
                w_occ_inc    = 1'b1;
            end else begin
                w_tries_next = w_tries_inc;
                w_state_next = (w_tries_inc == TR_W'(MAX_TRIES)) ? S_LOCK : S_WRONG_PASS;
            end
        end

        if (w_state_change && (w_state_next == S_IDLE)) w_tries_next = '0;
    end

    assign gate_bus.occupancy = r_occupancy;
    assign gate_bus.full      = w_full;
    assign gate_bus.locked    = (r_state == S_LOCK);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt  <= '0;
            r_tries     <= '0;
            r_occupancy <= '0;
            r_lock_cnt  <= '0;
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
            r_exit_pend <= 1'b0;
            r_exit_prev <= 1'b0;
        end else begin
            r_tries     <= w_tries_next;
            r_exit_prev <= gate_bus.exit;

            // A second exit edge while one is still pending is dropped.
            if (w_service)        r_exit_pend <= 1'b0;
            else if (w_exit_rise) r_exit_pend <= 1'b1;

            if (w_occ_inc && !w_full)
                r_occupancy <= r_occupancy + OCC_W'(1);
            else if (w_service && (r_occupancy != '0))
                r_occupancy <= r_occupancy - OCC_W'(1);

            if (w_state_change)
                r_wait_cnt <= '0;
            else if ((r_state == S_WAIT_PASS) && !w_wait_done)
                r_wait_cnt <= r_wait_cnt + WC_W'(1);

            if (w_state_change)
                r_lock_cnt <= '0;
            else if ((r_state == S_LOCK) && !w_lock_done)
                r_lock_cnt <= r_lock_cnt + LK_W'(1);

            if (w_state_change) begin
                r_blink     <= 1'b1;
                r_blink_cnt <= '0;
            end else if (w_blinking) begin
                if (w_blink_wrap) begin
                    r_blink     <= ~r_blink;
                    r_blink_cnt <= '0;
                end else begin
                    r_blink_cnt <= r_blink_cnt + BL_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed and randomized bench for parking_gate_ctrl, checked every cycle
// against a phase/age based reference model of the gate behaviour.
module tb_parking_gate_ctrl;

    localparam int              PW_W        = 2;
    localparam logic [PW_W-1:0] PASS1       = 2'b01;
    localparam logic [PW_W-1:0] PASS2       = 2'b10;
    localparam int              CAPACITY    = 8;
    localparam int              WAIT_CYCLES = 3;
    localparam int              MAX_TRIES   = 3;
    localparam int              LOCK_CYCLES = 16;
    localparam int              BLINK_DIV   = 4;

    localparam logic [6:0] H_BLANK = 7'h7F;
    localparam logic [6:0] H_F     = 7'b0001110;
    localparam logic [6:0] H_L     = 7'b1000111;
    localparam logic [6:0] H_E     = 7'b0000110;
    localparam logic [6:0] H_N     = 7'b0101011;
    localparam logic [6:0] H_G     = 7'b0000010;
    localparam logic [6:0] H_O     = 7'b1000000;
    localparam logic [6:0] H_S     = 7'b0010010;
    localparam logic [6:0] H_P     = 7'b0001100;

    logic clk = 1'b0;
    logic rst = 1'b1;

    parking_gate_ctrl_if #(.PW_W(PW_W), .CAPACITY(CAPACITY)) gate_if ();

    parking_gate_ctrl #(
        .PW_W(PW_W), .PASS1(PASS1), .PASS2(PASS2), .CAPACITY(CAPACITY),
        .WAIT_CYCLES(WAIT_CYCLES), .MAX_TRIES(MAX_TRIES),
        .LOCK_CYCLES(LOCK_CYCLES), .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .gate_bus (gate_if.slave)
    );

    always #5 clk = ~clk;

    typedef enum {M_IDLE, M_WAIT, M_WRONG, M_RIGHT, M_LOCK} phase_e;

    phase_e m_phase;
    int     m_age;
    int     m_tries;
    int     m_occ;
    bit     m_pend;
    bit     m_exit_prev;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase     = M_IDLE;
        m_age       = 0;
        m_tries     = 0;
        m_occ       = 0;
        m_pend      = 1'b0;
        m_exit_prev = 1'b0;
    endtask

    // Advance the reference model by one rising edge using the current inputs.
    task automatic model_edge();
        bit     was_full;
        bit     rise;
        bit     try_pw;
        phase_e nxt;
        if (!rst) begin
            model_reset();
            return;
        end
        was_full    = (m_occ == CAPACITY);
        rise        = gate_if.exit && !m_exit_prev;
        m_exit_prev = gate_if.exit;
        if (m_phase == M_IDLE && m_pend) begin
            if (m_occ > 0) m_occ--;
            m_pend = 1'b0;
        end else if (rise) begin
            m_pend = 1'b1;
        end
        nxt    = m_phase;
        try_pw = 1'b0;
        case (m_phase)
            M_IDLE:  if (gate_if.entry && !was_full) nxt = M_WAIT;
            M_WAIT:  if (!gate_if.entry) nxt = M_IDLE;
                     else try_pw = gate_if.pw_valid && (m_age >= WAIT_CYCLES);
            M_WRONG: if (!gate_if.entry) nxt = M_IDLE;
                     else try_pw = gate_if.pw_valid;
            M_RIGHT: if (!gate_if.entry) nxt = M_IDLE;
            M_LOCK:  if (m_age == LOCK_CYCLES - 1) nxt = M_IDLE;
            default: nxt = M_IDLE;
        endcase
        if (try_pw) begin
            if (gate_if.password1 == PASS1 && gate_if.password2 == PASS2) begin
                nxt     = M_RIGHT;
                m_tries = 0;
                if (m_occ < CAPACITY) m_occ++;
            end else begin
                m_tries++;
                nxt = (m_tries == MAX_TRIES) ? M_LOCK : M_WRONG;
            end
        end
        if (nxt != m_phase) begin
            m_phase = nxt;
            m_age   = 0;
            if (nxt == M_IDLE) m_tries = 0;
        end else begin
            m_age++;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic       e_green, e_red;
        logic [6:0] e_h1, e_h2;
        logic       blink;
        blink   = ((m_age / BLINK_DIV) % 2) == 0;
        e_green = 1'b0;
        e_red   = 1'b0;
        e_h1    = H_BLANK;
        e_h2    = H_BLANK;
        case (m_phase)
            M_IDLE:  if (m_occ == CAPACITY) begin e_red = 1'b1; e_h1 = H_F; e_h2 = H_L; end
            M_WAIT:  begin e_red = 1'b1;  e_h1 = H_E; e_h2 = H_N; end
            M_WRONG: begin e_red = blink; e_h1 = H_E; e_h2 = H_E; end
            M_RIGHT: begin e_green = blink; e_h1 = H_G; e_h2 = H_O; end
            M_LOCK:  begin e_red = 1'b1;  e_h1 = H_S; e_h2 = H_P; end
            default: ;
        endcase
        check($sformatf("%s.green", tag), gate_if.GREEN, e_green);
        check($sformatf("%s.red", tag), gate_if.RED, e_red);
        check($sformatf("%s.hex1", tag), gate_if.HEX_1, e_h1);
        check($sformatf("%s.hex2", tag), gate_if.HEX_2, e_h2);
        check($sformatf("%s.occ", tag), gate_if.occupancy, m_occ);
        check($sformatf("%s.full", tag), gate_if.full, m_occ == CAPACITY);
        check($sformatf("%s.locked", tag), gate_if.locked, m_phase == M_LOCK);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic set_pw(input logic [PW_W-1:0] p1, input logic [PW_W-1:0] p2, input logic v);
        gate_if.password1 = p1;
        gate_if.password2 = p2;
        gate_if.pw_valid  = v;
    endtask

    task automatic admit(input string tag);
        gate_if.entry = 1'b1;
        tick(tag);
        ticks(WAIT_CYCLES, tag);
        set_pw(PASS1, PASS2, 1'b1);
        tick(tag);
        gate_if.pw_valid = 1'b0;
        gate_if.entry    = 1'b0;
        tick(tag);
    endtask

    task automatic check_reset_values(input string tag);
        check($sformatf("%s.green", tag), gate_if.GREEN, 1'b0);
        check($sformatf("%s.red", tag), gate_if.RED, 1'b0);
        check($sformatf("%s.hex1", tag), gate_if.HEX_1, H_BLANK);
        check($sformatf("%s.hex2", tag), gate_if.HEX_2, H_BLANK);
        check($sformatf("%s.occ", tag), gate_if.occupancy, 0);
        check($sformatf("%s.full", tag), gate_if.full, 1'b0);
        check($sformatf("%s.locked", tag), gate_if.locked, 1'b0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        gate_if.entry = 1'b0;
        gate_if.exit  = 1'b0;
        set_pw('0, '0, 1'b0);
        model_reset();

        // Reset values
        #1 rst = 1'b0;
        #2 check_reset_values("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        ticks(10, "idle");

        // Correct password after the wait window
        #4 gate_if.entry = 1'b1;
        tick("enter");
        check("enter.red", gate_if.RED, 1'b1);
        check("enter.hex1", gate_if.HEX_1, H_E);
        ticks(WAIT_CYCLES, "wait");
        set_pw(PASS1, PASS2, 1'b1);
        tick("pass_ok");
        gate_if.pw_valid = 1'b0;
        check("pass_ok.occ", gate_if.occupancy, 1);
        check("pass_ok.green", gate_if.GREEN, 1'b1);
        check("pass_ok.hex2", gate_if.HEX_2, H_O);
        ticks(BLINK_DIV, "blink_lo");
        check("blink_lo.green", gate_if.GREEN, 1'b0);
        ticks(BLINK_DIV, "blink_hi");
        check("blink_hi.green", gate_if.GREEN, 1'b1);
        gate_if.entry = 1'b0;
        tick("passed");
        check("passed.hex1", gate_if.HEX_1, H_BLANK);

        // Early pw_valid is dropped, then three wrong attempts lock the gate
        gate_if.entry = 1'b1;
        tick("enter2");
        set_pw(PASS1, PASS2, 1'b1);
        tick("early_pw");
        gate_if.pw_valid = 1'b0;
        check("early_pw.hex2", gate_if.HEX_2, H_N);
        check("early_pw.occ", gate_if.occupancy, 1);
        ticks(WAIT_CYCLES - 1, "wait2");
        set_pw('0, '0, 1'b1);
        tick("wrong1");
        gate_if.pw_valid = 1'b0;
        check("wrong1.hex2", gate_if.HEX_2, H_E);
        check("wrong1.red", gate_if.RED, 1'b1);
        ticks(BLINK_DIV, "wrong_blink");
        check("wrong_blink.red", gate_if.RED, 1'b0);
        set_pw('0, '0, 1'b1);
        tick("wrong2");
        check("wrong2.locked", gate_if.locked, 1'b0);
        tick("wrong3");
        gate_if.pw_valid = 1'b0;
        check("wrong3.locked", gate_if.locked, 1'b1);
        check("wrong3.hex1", gate_if.HEX_1, H_S);
        ticks(LOCK_CYCLES - 1, "lock");
        check("lock_last.locked", gate_if.locked, 1'b1);
        tick("unlock");
        gate_if.entry = 1'b0;
        check("unlock.locked", gate_if.locked, 1'b0);
        check("unlock.red", gate_if.RED, 1'b0);
        tick("idle2");

        // Fill the car park
        for (int i = 0; i < CAPACITY - 1; i++) admit("fill");
        check("filled.occ", gate_if.occupancy, CAPACITY);
        check("filled.full", gate_if.full, 1'b1);
        gate_if.entry = 1'b1;
        ticks(2, "refused");
        check("refused.red", gate_if.RED, 1'b1);
        check("refused.hex1", gate_if.HEX_1, H_F);
        check("refused.hex2", gate_if.HEX_2, H_L);
        gate_if.exit = 1'b1;
        tick("exit_full");
        gate_if.exit = 1'b0;
        tick("exit_served");
        check("exit_served.occ", gate_if.occupancy, CAPACITY - 1);
        check("exit_served.full", gate_if.full, 1'b0);
        tick("accepted");
        check("accepted.hex1", gate_if.HEX_1, H_E);
        ticks(WAIT_CYCLES, "wait3");
        set_pw(PASS1, PASS2, 1'b1);
        tick("refill");
        gate_if.pw_valid = 1'b0;
        gate_if.entry    = 1'b0;
        tick("refill_idle");

        // Exit during WAIT_PASS is serviced on return to IDLE
        gate_if.exit = 1'b1;
        tick("exit_a");
        gate_if.exit = 1'b0;
        tick("exit_a2");
        gate_if.entry = 1'b1;
        tick("enter4");
        gate_if.exit = 1'b1;
        tick("exit_wait");
        gate_if.exit = 1'b0;
        tick("exit_wait2");
        check("exit_wait.occ", gate_if.occupancy, CAPACITY - 1);
        gate_if.entry = 1'b0;
        tick("abort");
        tick("serviced");
        check("serviced.occ", gate_if.occupancy, CAPACITY - 2);

        // Same-cycle entry and exit edge in IDLE
        gate_if.entry = 1'b1;
        gate_if.exit  = 1'b1;
        tick("both");
        gate_if.exit = 1'b0;
        check("both.hex1", gate_if.HEX_1, H_E);
        check("both.occ", gate_if.occupancy, CAPACITY - 2);
        ticks(2, "both_wait");
        gate_if.entry = 1'b0;
        tick("both_abort");
        tick("both_serviced");
        check("both_serviced.occ", gate_if.occupancy, CAPACITY - 3);

        // Drain to zero, then one more exit saturates
        for (int i = 0; i < CAPACITY - 3; i++) begin
            gate_if.exit = 1'b1;
            tick("drain");
            gate_if.exit = 1'b0;
            tick("drain");
        end
        gate_if.exit = 1'b1;
        tick("exit_zero");
        gate_if.exit = 1'b0;
        ticks(2, "exit_zero");
        check("exit_zero.occ", gate_if.occupancy, 0);

        // Asynchronous reset during RIGHT_PASS
        gate_if.entry = 1'b1;
        tick("enter5");
        ticks(WAIT_CYCLES, "wait5");
        set_pw(PASS1, PASS2, 1'b1);
        tick("pass5");
        gate_if.pw_valid = 1'b0;
        check("pass5.green", gate_if.GREEN, 1'b1);
        #3 rst = 1'b0;
        #1 check_reset_values("async_rst");
        model_reset();
        gate_if.entry = 1'b0;
        #2 rst = 1'b1;
        ticks(3, "post_rst");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) gate_if.entry = ~gate_if.entry;
            gate_if.exit     = ($urandom_range(0, 5) == 0);
            gate_if.pw_valid = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 1) begin
                gate_if.password1 = PASS1;
                gate_if.password2 = PASS2;
            end else begin
                gate_if.password1 = PW_W'($urandom_range(0, (1 << PW_W) - 1));
                gate_if.password2 = PW_W'($urandom_range(0, (1 << PW_W) - 1));
            end
            tick("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
